// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control FSM and the multiply/divide unit.
// master: control side that issues starts and reads HI/LO; slave: the unit itself.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start_mult, start_div, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit with HI/LO registers.
// Optional feature macro: MULTDIV_DIV_EN. When undefined, the divider is not built, start_div
// is ignored and div_zero is tied low; multiply behaviour and timing are unchanged.
// Datapath registers are shared between the two operations:
//   acc_q  : Booth upper accumulator / partial remainder
//   low_q  : Booth multiplier (Q) / dividend shifting out, quotient shifting in
//   opnd_q : multiplicand / divisor magnitude
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);

`ifdef MULTDIV_DIV_EN
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMult   = 2'd1,
        StDiv    = 2'd2,
        StFinish = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMult   = 2'd1,
        StFinish = 2'd3
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             q_m1_q, q_m1_d;

    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   booth_sum;

`ifdef MULTDIV_DIV_EN
    logic             div_zero_q, div_zero_d;
    logic             is_div_q, is_div_d;
    logic             dz_q, dz_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;
    logic [WIDTH-1:0] quot_signed;
    logic [WIDTH-1:0] rem_signed;

    // Magnitudes are taken as unsigned, so -2^31 maps cleanly to 0x80000000.
    assign a_mag       = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    assign b_mag       = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
    assign rem_shift   = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
    assign rem_trial   = rem_shift - {1'b0, opnd_q};
    assign quot_signed = neg_quot_q ? (~low_q + 1'b1) : low_q;
    assign rem_signed  = neg_rem_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
`else
    logic unused_start_div;
    assign unused_start_div = bus.start_div;
`endif

    assign mcand_ext = {opnd_q[WIDTH-1], opnd_q};

    // Booth recoding of {Q0, Q-1}: 01 adds the multiplicand, 10 subtracts it.
    always_comb begin
        booth_sum = acc_q;
        unique case ({low_q[0], q_m1_q})
            2'b01:   booth_sum = acc_q + mcand_ext;
            2'b10:   booth_sum = acc_q - mcand_ext;
            default: booth_sum = acc_q;
        endcase
    end

    // Next-state, datapath update and output pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        acc_d   = acc_q;
        low_d   = low_q;
        opnd_d  = opnd_q;
        q_m1_d  = q_m1_q;
`ifdef MULTDIV_DIV_EN
        div_zero_d = 1'b0;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.start_mult) begin
                    opnd_d  = bus.a;
                    low_d   = bus.b;
                    acc_d   = '0;
                    q_m1_d  = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = StMult;
`ifdef MULTDIV_DIV_EN
                    is_div_d = 1'b0;
                    dz_d     = 1'b0;
`endif
                end
`ifdef MULTDIV_DIV_EN
                else if (bus.start_div) begin
                    busy_d   = 1'b1;
                    is_div_d = 1'b1;
                    if (bus.b == '0) begin
                        dz_d    = 1'b1;
                        state_d = StFinish;
                    end else begin
                        dz_d       = 1'b0;
                        low_d      = a_mag;
                        opnd_d     = b_mag;
                        acc_d      = '0;
                        neg_quot_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        neg_rem_d  = bus.a[WIDTH-1];
                        cnt_d      = CNT_W'(WIDTH);
                        state_d    = StDiv;
                    end
                end
`endif
            end

            StMult: begin
                // Arithmetic shift right of {acc, Q, Q-1} after the Booth add.
                {acc_d, low_d, q_m1_d} = {booth_sum[WIDTH], booth_sum, low_q};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFinish;
                end
            end

`ifdef MULTDIV_DIV_EN
            StDiv: begin
                // Non-negative trial difference means the divisor fits: keep it, quotient bit 1.
                if (!rem_trial[WIDTH]) begin
                    acc_d = rem_trial;
                    low_d = {low_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_shift;
                    low_d = {low_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFinish;
                end
            end
`endif

            StFinish: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
`ifdef MULTDIV_DIV_EN
                if (dz_q) begin
                    div_zero_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_signed;
                    lo_d = quot_signed;
                end else begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = low_q;
                end
`else
                hi_d = acc_q[WIDTH-1:0];
                lo_d = low_q;
`endif
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
            low_q   <= '0;
            opnd_q  <= '0;
            q_m1_q  <= 1'b0;
`ifdef MULTDIV_DIV_EN
            div_zero_q <= 1'b0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            opnd_q  <= opnd_d;
            q_m1_q  <= q_m1_d;
`ifdef MULTDIV_DIV_EN
            div_zero_q <= div_zero_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef MULTDIV_DIV_EN
    assign bus.div_zero = div_zero_q;
`else
    assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level reference model compared every cycle, directed
// cases with literal expectations, then randomized start pulses and operands.
module tb_mult_div_unit;

`ifdef MULTDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    bit   chk_en;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    endtask

    // Reference arithmetic from plain signed 64-bit math.
    function automatic logic [63:0] ref_mult(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return sx * sy;
    endfunction

    // Returns {remainder, quotient}, truncating toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction model: an accepted start completes a fixed number of edges later.
    logic [31:0] m_hi, m_lo;
    logic        m_busy, m_done, m_dz;
    int          m_left;
    logic [63:0] p_res;
    logic        p_dz;

    always @(posedge clk) begin
        if (reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_left <= 0;
            p_dz   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_dz   <= p_dz;
                    if (!p_dz) begin
                        m_hi <= p_res[63:32];
                        m_lo <= p_res[31:0];
                    end
                end
            end else if (bus.start_mult) begin
                p_res  <= ref_mult(bus.a, bus.b);
                p_dz   <= 1'b0;
                m_left <= 33;
                m_busy <= 1'b1;
            end else if (bus.start_div && DivEn) begin
                m_busy <= 1'b1;
                if (bus.b == 32'd0) begin
                    p_dz   <= 1'b1;
                    m_left <= 1;
                end else begin
                    p_res  <= ref_div(bus.a, bus.b);
                    p_dz   <= 1'b0;
                    m_left <= 33;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_hi", {32'd0, bus.hi}, {32'd0, m_hi});
            chk("cyc_lo", {32'd0, bus.lo}, {32'd0, m_lo});
            chk("cyc_busy", {63'd0, bus.busy}, {63'd0, m_busy});
            chk("cyc_done", {63'd0, bus.done}, {63'd0, m_done});
            chk("cyc_div_zero", {63'd0, bus.div_zero}, {63'd0, m_dz});
        end
    end

    // One operation with literal expectations; elat == 0 means the start must be ignored.
    // inj >= 0 pulses both starts (with junk operands) that many cycles into the operation.
    task automatic do_op(input string name, input bit sm, input bit sd,
                         input logic [31:0] oa, input logic [31:0] ob,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input bit edz, input int elat, input int inj);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        bus.start_mult = sm;
        bus.start_div  = sd;
        bus.a          = oa;
        bus.b          = ob;
        @(negedge clk);
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && lat < 45) begin
            if (bus.busy) busy_cnt++;
            if (lat == inj) begin
                bus.start_mult = 1'b1;
                bus.start_div  = 1'b1;
                bus.a          = $urandom;
                bus.b          = $urandom;
            end else begin
                bus.start_mult = 1'b0;
                bus.start_div  = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (bus.done) seen = 1'b1;
        end
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        if (elat == 0) begin
            chk({name, "_no_done"}, {63'd0, seen}, 64'd0);
            chk({name, "_no_busy"}, 64'(busy_cnt), 64'd0);
        end else begin
            chk({name, "_latency"}, seen ? 64'(lat) : 64'hDEAD, 64'(elat));
            chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(elat));
        end
        chk({name, "_hi"}, {32'd0, bus.hi}, {32'd0, ehi});
        chk({name, "_lo"}, {32'd0, bus.lo}, {32'd0, elo});
        chk({name, "_div_zero"}, {63'd0, bus.div_zero}, {63'd0, edz});
    endtask

    function automatic logic [31:0] rand_opnd();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  cyc;
        bit  seen;
        n_pass         = 0;
        n_total        = 0;
        chk_en         = 1'b0;
        reset          = 1'b1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;

        // Pin the reference functions to hand-computed values.
        chk("model_mult_7_m3", ref_mult(32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_mult_min_min", ref_mult(32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
        chk("model_div_m7_2", ref_div(32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_div_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("reset_hi", {32'd0, bus.hi}, 64'd0);
        chk("reset_lo", {32'd0, bus.lo}, 64'd0);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);

        do_op("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33, -1);
        do_op("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 33, -1);
        do_op("mul_m1_m1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 0, 33, -1);
        do_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, DivEn ? 32'hFFFF_FFFF : 32'h0,
              DivEn ? 32'hFFFF_FFFD : 32'h1, 0, DivEn ? 33 : 0, -1);
        do_op("div_100_7", 0, 1, 32'd100, 32'd7, DivEn ? 32'd2 : 32'h0,
              DivEn ? 32'd14 : 32'h1, 0, DivEn ? 33 : 0, -1);
        do_op("div_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,
              DivEn ? 32'h8000_0000 : 32'h1, 0, DivEn ? 33 : 0, -1);
        // 0x66 * 0x2AAAAAAB = 0x11_0000_0022, preloading HI/LO for the divide-by-zero case.
        do_op("preload", 1, 0, 32'h66, 32'h2AAA_AAAB, 32'h11, 32'h22, 0, 33, -1);
        do_op("div_by_zero", 0, 1, 32'd5, 32'd0, 32'h11, 32'h22, DivEn, DivEn ? 1 : 0, -1);
        do_op("mul_inject", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33, 5);
        do_op("both_starts", 1, 1, 32'd100, 32'd7, 32'h0, 32'd700, 0, 33, -1);

        // Reset ten cycles into a divide.
        @(negedge clk);
        bus.start_div = 1'b1;
        bus.a         = 32'd100;
        bus.b         = 32'd7;
        @(negedge clk);
        bus.start_div = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_mid_lo", {32'd0, bus.lo}, 64'd0);
        chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("rst_mid_no_done", {63'd0, seen}, 64'd0);
        do_op("mul_3_4", 1, 0, 32'd3, 32'd4, 32'h0, 32'd12, 0, 33, -1);

        // Random start pulses, including while busy, checked by the per-cycle model compare.
        for (cyc = 0; cyc < 3000; cyc++) begin
            int unsigned r;
            @(negedge clk);
            r              = $urandom_range(0, 15);
            bus.start_mult = (r == 0) || (r == 2);
            bus.start_div  = (r == 1) || (r == 2) || (r == 3);
            bus.a          = rand_opnd();
            bus.b          = rand_opnd();
            if (cyc % 500 == 499) reset = 1'b1;
            else reset = 1'b0;
        end
        @(negedge clk);
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        reset          = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
